// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Supports a synchronous flush and counts back-pressured cycles (saturating).
module pipe_skid_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              acc;
  logic              rel;
  logic              stall;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  assign acc   = in_valid && in_ready;
  assign rel   = out_valid && out_ready;
  assign stall = out_valid && !out_ready;

  // out_ctrl is cleared whenever the main slot goes invalid,
  // so bubbles never carry write enables downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      out_ctrl <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
            state    <= ONE;
          end
        end
        ONE: begin
          if (acc && rel) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end else if (acc) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= FULL;
          end else if (rel) begin
            out_ctrl <= '0;
            state    <= EMPTY;
          end
        end
        FULL: begin
          if (rel) begin
            out_data <= skid_data;
            out_ctrl <= skid_ctrl;
            state    <= ONE;
          end
        end
        default: begin
          out_ctrl <= '0;
          state    <= EMPTY;
        end
      endcase
    end
  end

  // Saturating stall counter; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
